// File: rtl/tx_ffe_pkg.sv
// Shared types and constants for the 3-tap FFE transmit driver.
package tx_ffe_pkg;

    // Serializer FSM states
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Line symbol: +1, -1, or 0 when nothing is being sent
    typedef logic signed [1:0] sym_t;

    localparam sym_t SYM_ZERO = 2'sb00;
    localparam sym_t SYM_POS  = 2'sb01;
    localparam sym_t SYM_NEG  = 2'sb11;

    // Source resistance presented to the line while the driver is off
    localparam real RS_OFF_DEFAULT = 1.0e6;

    // Convert a symbol to its real-valued weight for the FIR
    function automatic real sym_to_real(input sym_t s);
        if (s == SYM_POS) begin
            return 1.0;
        end else if (s == SYM_NEG) begin
            return -1.0;
        end else begin
            return 0.0;
        end
    endfunction

endpackage

// File: rtl/tx_ffe_ser.sv
// Parallel-to-serial symbol generator: accepts WIDTH-bit words and emits
// one symbol per clock, LSB first, with seamless back-to-back words.
module tx_ffe_ser
    import tx_ffe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output sym_t             sym,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] shreg_reg, shreg_next;
    logic             accept;

    assign accept = din_valid & din_ready;

    // State register: reset wins over everything else
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            shreg_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            shreg_reg <= shreg_next;
        end
    end

    // Next-state logic: disable aborts, otherwise load / shift / reload
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shreg_next = shreg_reg;
        if (!en) begin
            state_next = IDLE;
            cnt_next   = '0;
            shreg_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        shreg_next = din;
                        cnt_next   = '0;
                        state_next = RUN;
                    end
                end
                RUN: begin
                    shreg_next = shreg_reg >> 1;
                    cnt_next   = cnt_reg + CW'(1);
                    if (cnt_reg == CNT_LAST) begin
                        if (accept) begin
                            // Reload on the last bit so no idle symbol is inserted
                            shreg_next = din;
                            cnt_next   = '0;
                        end else begin
                            state_next = IDLE;
                            cnt_next   = '0;
                            shreg_next = '0;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    shreg_next = '0;
                end
            endcase
        end
    end

    // Outputs: current symbol, handshake and busy flag
    always_comb begin
        sym       = SYM_ZERO;
        busy      = (state_reg == RUN);
        din_ready = en & ~rst & ((state_reg == IDLE) | (cnt_reg == CNT_LAST));
        if (state_reg == RUN) begin
            sym = shreg_reg[0] ? SYM_POS : SYM_NEG;
        end
    end

endmodule

// File: rtl/tx_ffe_driver.sv
// Transmit driver with 3-tap feed-forward equalization: serializes parallel
// words, keeps a pre/main/post symbol history and drives a weighted voltage
// together with the matching source resistance.
module tx_ffe_driver
    import tx_ffe_pkg::*;
#(
    parameter int  WIDTH  = 8,
    parameter real VSWING = 1.0,
    parameter real C_PRE  = -0.1,
    parameter real C_MAIN = 0.7,
    parameter real C_POST = -0.2,
    parameter real RS     = 50.0,
    parameter real RS_OFF = RS_OFF_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output real              vout,
    output real              rs_out,
    output logic             busy
);

    sym_t sym;
    sym_t s_pre_reg, s_cur_reg, s_post_reg;

    tx_ffe_ser #(
        .WIDTH (WIDTH)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .sym       (sym),
        .busy      (busy)
    );

    // Symbol history and FIR output; vout uses the values being loaded this edge
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            s_pre_reg  <= SYM_ZERO;
            s_cur_reg  <= SYM_ZERO;
            s_post_reg <= SYM_ZERO;
            vout       <= 0.0;
        end else begin
            s_pre_reg  <= sym;
            s_cur_reg  <= s_pre_reg;
            s_post_reg <= s_cur_reg;
            vout       <= VSWING * (C_PRE  * sym_to_real(sym)
                                  + C_MAIN * sym_to_real(s_pre_reg)
                                  + C_POST * sym_to_real(s_cur_reg));
        end
    end

    // Source resistance: high impedance whenever the driver is not active
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            rs_out <= RS_OFF;
        end else begin
            rs_out <= RS;
        end
    end

endmodule

// File: tb/tb_tx_ffe_driver.sv
// Directed self-checking bench for tx_ffe_driver (WIDTH=4).
module tb_tx_ffe_driver;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    real          vout;
    real          rs_out;
    logic         busy;

    int n_cmp = 0;
    int n_mis = 0;
    int exp_q[$];   // expected vout in millivolts, one entry per clock

    tx_ffe_driver #(
        .WIDTH  (W),
        .VSWING (1.0),
        .C_PRE  (-0.1),
        .C_MAIN (0.7),
        .C_POST (-0.2),
        .RS     (50.0),
        .RS_OFF (1.0e6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .vout      (vout),
        .rs_out    (rs_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int mv(input real v);
        return int'(v * 1000.0);
    endfunction

    // Step n clocks, popping and comparing one expected vout per clock
    task automatic run_stream(input string tag, input int n);
        int e;
        for (int i = 0; i < n; i++) begin
            step();
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL %s: scoreboard empty, observed %0d", tag, mv(vout));
            end else begin
                e = exp_q.pop_front();
                chk(tag, mv(vout), e);
                $display("%s: vout=%0d mV expected %0d mV", tag, mv(vout), e);
            end
        end
    endtask

    // Present a word, confirm it is ready to be taken, clock it in, drop valid
    task automatic accept_word(input string tag, input logic [W-1:0] w);
        din       = w;
        din_valid = 1'b1;
        #1;
        chk({tag, "_ready"}, int'(din_ready), 1);
        step();
        din_valid = 1'b0;
    endtask

    task automatic push_0001();
        exp_q.push_back(-100); exp_q.push_back(800);  exp_q.push_back(-800);
        exp_q.push_back(-400); exp_q.push_back(-500); exp_q.push_back(200);
        exp_q.push_back(0);
    endtask

    task automatic chk_off(input string tag);
        chk({tag, "_vout"},  mv(vout), 0);
        chk({tag, "_rs"},    int'(rs_out), 1000000);
        chk({tag, "_ready"}, int'(din_ready), 0);
        chk({tag, "_busy"},  int'(busy), 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; din = '0; din_valid = 1'b0;

        // Reset held for three cycles with the driver enabled
        step(); step(); step();
        chk_off("reset");
        rst = 1'b0;
        #1;
        chk("post_rst_ready", int'(din_ready), 1);
        step();
        chk("post_rst_rs", int'(rs_out), 50);
        chk("post_rst_vout", mv(vout), 0);

        // Single word 0001 followed by idle
        accept_word("single", 4'b0001);
        push_0001();
        run_stream("single", 3);
        chk("single_busy_hi", int'(busy), 1);
        run_stream("single", 1);
        chk("single_busy_lo", int'(busy), 0);
        run_stream("single", 3);

        // Back-to-back 4'hF words with valid held through the reload
        din = 4'hF; din_valid = 1'b1;
        #1;
        chk("b2b_ready_k", int'(din_ready), 1);
        step();
        exp_q.push_back(-100); exp_q.push_back(600);
        for (int i = 0; i < 6; i++) exp_q.push_back(400);
        exp_q.push_back(500); exp_q.push_back(-200); exp_q.push_back(0);
        run_stream("b2b", 3);
        chk("b2b_ready_k4", int'(din_ready), 1);
        run_stream("b2b", 1);
        din_valid = 1'b0;
        run_stream("b2b", 7);

        // Enable dropped after two bits of 1010
        accept_word("abort", 4'b1010);
        exp_q.push_back(100); exp_q.push_back(-800);
        run_stream("abort", 2);
        en = 1'b0;
        step();
        chk_off("abort_off");
        step();
        en = 1'b1;
        step();
        chk("reen_rs", int'(rs_out), 50);
        accept_word("reen", 4'b0001);
        push_0001();
        run_stream("reen", 7);

        // Reset pulsed mid-word while a new word is already offered
        accept_word("midrst", 4'b1010);
        exp_q.push_back(100);
        run_stream("midrst", 1);
        rst = 1'b1; din = 4'b0001; din_valid = 1'b1;
        step();
        chk_off("midrst_off");
        rst = 1'b0;
        #1;
        chk("midrst_ready", int'(din_ready), 1);
        step();
        din_valid = 1'b0;
        push_0001();
        run_stream("midrst_new", 7);

        // Idle gap, then restart with the normal latency
        for (int i = 0; i < 3; i++) exp_q.push_back(0);
        run_stream("idle", 3);
        chk("idle_busy", int'(busy), 0);
        accept_word("restart", 4'hF);
        exp_q.push_back(-100); exp_q.push_back(600); exp_q.push_back(400);
        run_stream("restart", 3);

        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
